// File: rtl/conv_layer_pkg.sv
// rtl/conv_layer_pkg.sv - shared FSM states, default geometry and RAM index helpers for conv_layer_core
package conv_layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int DEF_IMG_W  = 32;
    localparam int DEF_IMG_H  = 32;
    localparam int DEF_IN_CH  = 3;
    localparam int DEF_OUT_CH = 32;
    localparam int DEF_KSIZE  = 5;
    localparam int DEF_SHIFT  = 7;

    function automatic logic [15:0] img_index(input int c, input int y, input int x,
                                               input int h, input int w);
        return 16'((c * h + y) * w + x);
    endfunction

    function automatic logic [15:0] wgt_index(input int k, input int c, input int ky, input int kx,
                                               input int in_ch, input int ksize);
        return 16'(((k * in_ch + c) * ksize + ky) * ksize + kx);
    endfunction

    function automatic logic [15:0] out_index(input int k, input int y, input int x,
                                               input int h, input int w);
        return 16'((k * h + y) * w + x);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - product register, accumulator, bias add and output clamp for one convolution pixel
// CONV_SAT_EN selects saturation to [-128, 127]; otherwise the low byte wraps.
module conv_mac
    import conv_layer_pkg::*;
#(
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              tap_valid,
    input  logic              tap_zero,
    input  logic signed [7:0] signal,
    input  logic signed [7:0] weight,
    input  logic signed [7:0] bias,
    input  logic              wr,
    output logic signed [7:0] convout
);

    logic signed [15:0] sig_ext;
    logic signed [15:0] wgt_ext;
    logic signed [15:0] prod_q;
    logic               prod_v_q;
    logic signed [31:0] acc_q;
    logic signed [7:0]  res8;

    // Padding taps still fetch a weight, but their pixel operand is replaced by zero.
    always_comb begin
        sig_ext = tap_zero ? 16'sd0 : {{8{signal[7]}}, signal};
        wgt_ext = {{8{weight[7]}}, weight};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else if (en) begin
            prod_q   <= sig_ext * wgt_ext;
            prod_v_q <= tap_valid;
            if (clr) begin
                acc_q <= '0;
            end else if (prod_v_q) begin
                acc_q <= acc_q + $signed({{16{prod_q[15]}}, prod_q});
            end
        end
    end

`ifdef CONV_SAT_EN
    logic signed [31:0] result;

    always_comb begin
        result = (acc_q >>> SHIFT) + $signed({{24{bias[7]}}, bias});
        if (result > 32'sd127) begin
            res8 = 8'sd127;
        end else if (result < -32'sd128) begin
            res8 = -8'sd128;
        end else begin
            res8 = result[7:0];
        end
    end
`else
    always_comb begin
        res8 = 8'(acc_q >>> SHIFT) + bias;
    end
`endif

    assign convout = wr ? res8 : 8'sd0;

endmodule

// File: rtl/conv_layer_core.sv
// rtl/conv_layer_core.sv - zero-padded KSIZE x KSIZE convolution layer sequencer driving image/weight/bias/output RAMs
// Output clamping is selected by CONV_SAT_EN (see conv_mac).
module conv_layer_core
    import conv_layer_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int IN_CH  = DEF_IN_CH,
    parameter int OUT_CH = DEF_OUT_CH,
    parameter int KSIZE  = DEF_KSIZE,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_ctrl,
    output logic [15:0]       s_addr,
    output logic [15:0]       w_addr,
    output logic [15:0]       b_addr,
    output logic [15:0]       save_addr,
    output logic              en_read,
    input  logic signed [7:0] signal,
    input  logic signed [7:0] weight,
    input  logic signed [7:0] bias,
    output logic signed [7:0] convout,
    output logic              en_write,
    output logic              finish
);

    localparam int PAD = KSIZE / 2;

    state_t      state_q;
    logic [15:0] x_q, y_q, k_q;
    logic [15:0] kx_q, ky_q, c_q;
    logic        drain_q;
    logic        last_q;
    logic        rd_q;
    logic        wr_q;
    logic        tap_vld_q;
    logic        rd_d1_q;
    logic        vld_d1_q;

    logic [15:0] nkx, nky, nc;
    logic [15:0] ax, ay, ac;
    logic        tap_last;
    logic        px_last;
    logic        start_px;
    logic        a_valid;
    logic [15:0] a_saddr;
    logic [15:0] a_waddr;
    int          ix, iy;

    // Addresses are registered one tap ahead: the lookahead tap is tap 0 when a pixel starts.
    always_comb begin
        nkx = kx_q + 16'd1;
        nky = ky_q;
        nc  = c_q;
        if (kx_q == 16'(KSIZE - 1)) begin
            nkx = '0;
            nky = ky_q + 16'd1;
            if (ky_q == 16'(KSIZE - 1)) begin
                nky = '0;
                nc  = c_q + 16'd1;
            end
        end
        tap_last = (kx_q == 16'(KSIZE - 1)) && (ky_q == 16'(KSIZE - 1)) && (c_q == 16'(IN_CH - 1));
        px_last  = (x_q == 16'(IMG_W - 1)) && (y_q == 16'(IMG_H - 1)) && (k_q == 16'(OUT_CH - 1));
        start_px = (state_q == ST_IDLE) || ((state_q == ST_NEXT) && !last_q);

        ax = (state_q == ST_READ) ? nkx : 16'd0;
        ay = (state_q == ST_READ) ? nky : 16'd0;
        ac = (state_q == ST_READ) ? nc  : 16'd0;

        ix = int'(x_q) + int'(ax) - PAD;
        iy = int'(y_q) + int'(ay) - PAD;
        a_valid = (ix >= 0) && (ix < IMG_W) && (iy >= 0) && (iy < IMG_H);
        a_saddr = a_valid ? img_index(int'(ac), iy, ix, IMG_H, IMG_W) : 16'd0;
        a_waddr = wgt_index(int'(k_q), int'(ac), int'(ay), int'(ax), IN_CH, KSIZE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            c_q       <= '0;
            drain_q   <= 1'b0;
            last_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            tap_vld_q <= 1'b0;
            rd_d1_q   <= 1'b0;
            vld_d1_q  <= 1'b0;
            s_addr    <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            save_addr <= '0;
            finish    <= 1'b0;
        end else if (en_ctrl) begin
            rd_d1_q  <= rd_q;
            vld_d1_q <= tap_vld_q;
            if (start_px) begin
                state_q   <= ST_READ;
                kx_q      <= '0;
                ky_q      <= '0;
                c_q       <= '0;
                rd_q      <= 1'b1;
                s_addr    <= a_saddr;
                w_addr    <= a_waddr;
                tap_vld_q <= a_valid;
                b_addr    <= k_q;
            end else begin
                case (state_q)
                    ST_READ: begin
                        if (tap_last) begin
                            state_q <= ST_DRAIN;
                            rd_q    <= 1'b0;
                            drain_q <= 1'b0;
                        end else begin
                            kx_q      <= nkx;
                            ky_q      <= nky;
                            c_q       <= nc;
                            s_addr    <= a_saddr;
                            w_addr    <= a_waddr;
                            tap_vld_q <= a_valid;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_q) begin
                            state_q   <= ST_WRITE;
                            wr_q      <= 1'b1;
                            save_addr <= out_index(int'(k_q), int'(y_q), int'(x_q), IMG_H, IMG_W);
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        state_q <= ST_NEXT;
                        wr_q    <= 1'b0;
                        last_q  <= px_last;
                        if (!px_last) begin
                            if (x_q == 16'(IMG_W - 1)) begin
                                x_q <= '0;
                                if (y_q == 16'(IMG_H - 1)) begin
                                    y_q <= '0;
                                    k_q <= k_q + 16'd1;
                                end else begin
                                    y_q <= y_q + 16'd1;
                                end
                            end else begin
                                x_q <= x_q + 16'd1;
                            end
                        end
                    end
                    ST_NEXT: begin
                        state_q <= ST_DONE;
                        finish  <= 1'b1;
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign en_read  = rd_q & en_ctrl;
    assign en_write = wr_q & en_ctrl;

    conv_mac #(
        .SHIFT(SHIFT)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en       (en_ctrl),
        .clr      ((state_q == ST_NEXT) || (state_q == ST_IDLE)),
        .tap_valid(rd_d1_q),
        .tap_zero (~vld_d1_q),
        .signal   (signal),
        .weight   (weight),
        .bias     (bias),
        .wr       (en_write),
        .convout  (convout)
    );

endmodule

// File: tb/tb_conv_layer_core.sv
// tb/tb_conv_layer_core.sv - self-checking bench for conv_layer_core (honours CONV_SAT_EN)
module tb_conv_layer_core;

    localparam int W   = 6;
    localparam int H   = 5;
    localparam int IC  = 2;
    localparam int OC  = 3;
    localparam int K   = 5;
    localparam int SH  = 6;
    localparam int PAD = K / 2;
    localparam int CPP = K * K * IC + 4;
    localparam int P   = OC * H * W;
    localparam int NI  = IC * H * W;
    localparam int NW  = OC * IC * K * K;

    logic              clk;
    logic              reset;
    logic              en_ctrl;
    logic [15:0]       s_addr, w_addr, b_addr, save_addr;
    logic              en_read, en_write, finish;
    logic signed [7:0] signal, weight, bias, convout;

    byte img_m [NI];
    byte w_m   [NW];
    byte b_m   [OC];
    int  exp_out [P];
    int  got     [P];
    int  wr_idx;
    int  n_pass, n_total;

    conv_layer_core #(
        .IMG_W(W), .IMG_H(H), .IN_CH(IC), .OUT_CH(OC), .KSIZE(K), .SHIFT(SH)
    ) dut (
        .clk(clk), .reset(reset), .en_ctrl(en_ctrl),
        .s_addr(s_addr), .w_addr(w_addr), .b_addr(b_addr), .save_addr(save_addr),
        .en_read(en_read), .signal(signal), .weight(weight), .bias(bias),
        .convout(convout), .en_write(en_write), .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAMs: registered read, output held while not enabled.
    always @(posedge clk) begin
        if (en_read) begin
            signal <= (int'(s_addr) < NI) ? img_m[int'(s_addr)] : 8'sd0;
            weight <= (int'(w_addr) < NW) ? w_m[int'(w_addr)] : 8'sd0;
        end
        bias <= (int'(b_addr) < OC) ? b_m[int'(b_addr)] : 8'sd0;
    end

    task automatic chk(input string name, input int got_v, input int exp_v);
        n_total++;
        if (got_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got_v, exp_v);
    endtask

    function automatic int model(input int k, input int y, input int x);
        int acc, r, iy, ix;
        acc = 0;
        for (int c = 0; c < IC; c++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++) begin
                    iy = y + ky - PAD;
                    ix = x + kx - PAD;
                    if (iy >= 0 && iy < H && ix >= 0 && ix < W)
                        acc += int'(img_m[(c * H + iy) * W + ix]) * int'(w_m[((k * IC + c) * K + ky) * K + kx]);
                end
        r = (acc >>> SH) + int'(b_m[k]);
`ifdef CONV_SAT_EN
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
`else
        r = int'(byte'(r));
`endif
        return r;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_s_addr"}, int'(s_addr), 0);
        chk({tag, "_w_addr"}, int'(w_addr), 0);
        chk({tag, "_b_addr"}, int'(b_addr), 0);
        chk({tag, "_save_addr"}, int'(save_addr), 0);
        chk({tag, "_convout"}, int'(convout), 0);
        chk({tag, "_en_read"}, int'(en_read), 0);
        chk({tag, "_en_write"}, int'(en_write), 0);
        chk({tag, "_finish"}, int'(finish), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NI; i++) img_m[i] = byte'($urandom_range(0, 255));
        for (int i = 0; i < NW; i++) w_m[i] = byte'(int'($urandom_range(0, 7)) - 4);
        for (int i = 0; i < OC; i++) b_m[i] = byte'($urandom_range(0, 255));
    endtask

    task automatic run(input int freeze_at, input int reset_at);
        int cyc, first_wr;
        bit done;
        reset = 1'b1;
        en_ctrl = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < OC; k++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    exp_out[(k * H + y) * W + x] = model(k, y, x);
                    got[(k * H + y) * W + x] = -1000;
                end
        wr_idx = 0;
        en_ctrl = 1'b1;
        cyc = 0;
        first_wr = -1;
        done = 1'b0;
        while (!done && cyc < P * CPP + 200) begin
            @(posedge clk); #1;
            cyc++;
            if (en_write && first_wr < 0) first_wr = cyc;
            if (finish) done = 1'b1;
            if (freeze_at > 0 && cyc == freeze_at + 5) chk("frozen_en_read", int'(en_read), 0);
            if (freeze_at > 0 && cyc == freeze_at) en_ctrl = 1'b0;
            if (freeze_at > 0 && cyc == freeze_at + 10) en_ctrl = 1'b1;
            if (reset_at > 0 && cyc == reset_at) begin
                chk("pre_reset_en_read", int'(en_read), 1);
                reset = 1'b1;
                @(posedge clk); #1;
                check_zero("midrun_reset");
                reset = 1'b0;
                return;
            end
        end
        chk("run_cycles", cyc, P * CPP + 1 + ((freeze_at > 0) ? 10 : 0));
        chk("first_write_cycle", first_wr, CPP - 1);
        repeat (5) @(posedge clk);
        #1;
        chk("write_count", wr_idx, P);
        chk("finish_sticky", int'(finish), 1);
        chk("done_no_read", int'(en_read), 0);
        chk("done_no_write", int'(en_write), 0);
    endtask

    initial begin
        reset = 1'b1;
        en_ctrl = 1'b0;
        n_pass = 0;
        n_total = 0;
        wr_idx = 0;

        fork
            forever begin
                @(negedge clk);
                if (!reset && en_write) begin
                    chk("save_addr_order", int'(save_addr), wr_idx);
                    if (int'(save_addr) < P) begin
                        chk("convout_vs_model", int'(convout), exp_out[int'(save_addr)]);
                        got[int'(save_addr)] = int'(convout);
                    end
                    wr_idx++;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        // Ones through weight 64 with shift 6: count of in-image taps per pixel.
        for (int i = 0; i < NI; i++) img_m[i] = 8'sd1;
        for (int i = 0; i < NW; i++) w_m[i] = 8'sd64;
        for (int i = 0; i < OC; i++) b_m[i] = 8'sd0;
        run(0, 0);
        chk("ones_corner", got[0], 18);
        chk("ones_edge", got[12], 30);
        chk("ones_interior", got[44], 50);

        for (int i = 0; i < NW; i++) w_m[i] = 8'sd0;
        for (int i = 0; i < OC; i++) b_m[i] = 8'sd5;
        run(0, 0);
        chk("bias_only_first", got[0], 5);
        chk("bias_only_last", got[P - 1], 5);

        for (int i = 0; i < NI; i++) img_m[i] = 8'sd127;
        for (int i = 0; i < NW; i++) w_m[i] = 8'sd127;
        for (int i = 0; i < OC; i++) b_m[i] = 8'sd0;
        run(0, 0);
`ifdef CONV_SAT_EN
        chk("max_interior", got[75], 127);
`else
        chk("max_interior", got[75], 56);
`endif

        // Centre tap of (k=0, c=0) = 64 passes channel 0 straight through.
        for (int i = 0; i < NI; i++) img_m[i] = byte'(i - 30);
        for (int i = 0; i < NW; i++) w_m[i] = 8'sd0;
        w_m[PAD * K + PAD] = 8'sd64;
        b_m[0] = 8'sd0;
        b_m[1] = -8'sd7;
        b_m[2] = 8'sd33;
        run(0, 0);
        for (int i = 0; i < H * W; i++) chk("passthrough_ch0", got[i], i - 30);
        chk("passthrough_ch1_bias", got[H * W], -7);
        chk("passthrough_ch2_bias", got[P - 1], 33);

        fill_random();
        run(200, 0);

        fill_random();
        run(0, 300);
        fill_random();
        run(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
